// File: rtl/ir_sweep_seq.sv
// Eight-channel IR sensor sweep sequencer: drives the A2D, banks results, flags lines above threshold.
// Optional macro SWEEP_AVG_EN converts each channel twice and stores the truncated average.
module ir_sweep_seq #(
  parameter int GAP_CYCLES = 32,
  parameter int NUM_CH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [11:0] thresh,
  input  logic [2:0]  rd_sel,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        busy,
  output logic        sweep_done,
  output logic [11:0] rd_val,
  output logic [7:0]  line_mask
);

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  gap_cnt;
  logic [11:0] bank [NUM_CH];
  logic [11:0] store_val;
  logic        last_conv;
  logic        repeat_ch;
  logic [7:0]  mask_next;

`ifdef SWEEP_AVG_EN
  logic        second;
  logic [11:0] first_res;
  logic [12:0] sum;

  assign sum       = {1'b0, first_res} + {1'b0, res};
  assign store_val = sum[12:1];
  assign last_conv = second;
  assign repeat_ch = second;
`else
  assign store_val = res;
  assign last_conv = 1'b1;
  assign repeat_ch = 1'b0;
`endif

  // Final channel is compared against the value being written this cycle,
  // so line_mask is valid in the same cycle sweep_done rises.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
      if (gi == NUM_CH - 1) begin : g_last
        assign mask_next[gi] = store_val > thresh;
      end else begin : g_prev
        assign mask_next[gi] = bank[gi] > thresh;
      end
    end
  endgenerate

  assign rd_val = bank[rd_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      line_mask  <= '0;
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
`ifdef SWEEP_AVG_EN
      second     <= 1'b0;
      first_res  <= '0;
`endif
    end else begin
      strt_cnv   <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            idx      <= '0;
            chnnl    <= '0;
            strt_cnv <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (cnv_cmplt) begin
`ifdef SWEEP_AVG_EN
            first_res <= res;
            second    <= ~second;
`endif
            if (last_conv) bank[idx] <= store_val;
            if (last_conv && idx == 3'(NUM_CH - 1)) begin
              state      <= DONE;
              sweep_done <= 1'b1;
              busy       <= 1'b0;
              line_mask  <= mask_next;
            end else begin
              gap_cnt <= 8'(GAP_CYCLES);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            strt_cnv <= 1'b1;
            state    <= START;
            if (repeat_ch) begin
              chnnl <= idx;
            end else begin
              idx   <= idx + 3'd1;
              chnnl <= idx + 3'd1;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_sweep_seq.sv
// Bench for ir_sweep_seq: behavioural A2D model, scoreboard of banked results, sweep vector table.
module tb_ir_sweep_seq;

  localparam int GAP = 4;
`ifdef SWEEP_AVG_EN
  localparam int CONV = 2;
`else
  localparam int CONV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, go, cnv_cmplt;
  logic [11:0] res, thresh;
  logic [2:0]  rd_sel;
  logic        strt_cnv, busy, sweep_done;
  logic [2:0]  chnnl;
  logic [11:0] rd_val;
  logic [7:0]  line_mask;

  ir_sweep_seq #(.GAP_CYCLES(GAP), .NUM_CH(8)) dut (
    .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .res(res),
    .thresh(thresh), .rd_sel(rd_sel), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .busy(busy), .sweep_done(sweep_done), .rd_val(rd_val), .line_mask(line_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
  } sb_t;

  typedef struct {
    int         base;
    int         step;
    logic [11:0] thr;
    int         lat;
    logic [7:0] mask;
    bit         stray;
    bit         dup;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[5];
  logic [11:0] res_tab[8];
  int          total = 0, bad = 0;
  int          cyc = 0, last_strt = 0;
  int          conv_cnt = 0, done_cnt = 0, lat_cfg = 1;
  bit          stray_en = 0, alt_en = 0;
  logic [7:0]  prev_mask = 8'h00, cur_emask = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // A2D model: answers each strt_cnv after lat_cfg cycles and logs the expected bank value
  initial begin : a2d_model
    logic [2:0]  ch;
    logic [11:0] rv, first_v, exp_v;
    bit          is_second;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    first_v   = 12'h000;
    forever begin
      @(posedge clk); #1;
      if (strt_cnv && !rst) begin
        ch = chnnl;
        chk("chnnl_order", 32'(chnnl), 32'(conv_cnt / CONV));
        chk("busy_in_sweep", 32'(busy), 32'd1);
        chk("mask_hold", 32'(line_mask), 32'(prev_mask));
        if (conv_cnt > 0) chk("strt_spacing", 32'(cyc - last_strt), 32'(1 + lat_cfg + GAP + 1));
        last_strt = cyc;
        is_second = (CONV == 2) && (conv_cnt % 2 == 1);
        conv_cnt++;
        rv = res_tab[ch];
        if (is_second && alt_en) rv = rv - 12'd1;
        if (!is_second) first_v = rv;
        repeat (lat_cfg) @(posedge clk);
        #1;
        cnv_cmplt = 1'b1;
        res       = rv;
        if (CONV == 1 || is_second) begin
          exp_v = (CONV == 1) ? rv : 12'((13'(first_v) + 13'(rv)) >> 1);
          sb.push_back('{ch: ch, val: exp_v});
        end
        @(posedge clk); #1;
        cnv_cmplt = 1'b0;
        res       = 12'h5A5;
        if (stray_en) begin
          @(posedge clk); #1;
          cnv_cmplt = 1'b1;
          res       = 12'hABC;
          @(posedge clk); #1;
          cnv_cmplt = 1'b0;
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(posedge clk); #1;
      if (sweep_done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("mask_at_done", 32'(line_mask), 32'(cur_emask));
      end
    end
  end

  task automatic load_tab(input int base, input int step);
    for (int i = 0; i < 8; i++) res_tab[i] = 12'(base + step * i);
  endtask

  task automatic run_sweep(input int base, input int step, input logic [11:0] thr, input int lat,
                           input logic [7:0] emask, input bit stray, input bit dup, input bit alt);
    bit  dup_sent = 0;
    sb_t e;
    load_tab(base, step);
    thresh    = thr;
    lat_cfg   = lat;
    stray_en  = stray;
    alt_en    = alt;
    cur_emask = emask;
    conv_cnt  = 0;
    done_cnt  = 0;
    sb.delete();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      @(negedge clk);
      if (dup && !dup_sent && conv_cnt >= 2) begin
        go = 1'b1;
        @(negedge clk) go = 1'b0;
        dup_sent = 1;
      end
    end
    if (done_cnt == 0) chk("sweep_timeout", 32'd0, 32'd1);
    repeat (40) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("conv_count", 32'(conv_cnt), 32'(8 * CONV));
    chk("line_mask", 32'(line_mask), 32'(emask));
    chk("sb_entries", 32'(sb.size()), 32'd8);
    while (sb.size() > 0) begin
      e      = sb.pop_front();
      rd_sel = e.ch;
      #1;
      chk("bank_value", 32'(rd_val), 32'(e.val));
    end
    $display("sweep base=%0d step=%0d thr=%0d lat=%0d stray=%0d dup=%0d mask=%02h convs=%0d",
             base, step, thr, lat, stray, dup, line_mask, conv_cnt);
    prev_mask = emask;
  endtask

  initial begin : main
    vecs[0] = '{base: 100,  step: 100, thr: 12'd450,  lat: 1,  mask: 8'hF0, stray: 0, dup: 0};
    vecs[1] = '{base: 350,  step: 50,  thr: 12'd450,  lat: 3,  mask: 8'hF8, stray: 1, dup: 0};
    vecs[2] = '{base: 0,    step: 0,   thr: 12'd0,    lat: 2,  mask: 8'h00, stray: 0, dup: 1};
    vecs[3] = '{base: 4095, step: 0,   thr: 12'd4094, lat: 20, mask: 8'hFF, stray: 0, dup: 0};
    vecs[4] = '{base: 10,   step: 500, thr: 12'd1000, lat: 4,  mask: 8'hFC, stray: 1, dup: 1};

    rst = 1'b1; go = 1'b0; thresh = '0; rd_sel = '0;
    load_tab(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_strt_cnv", 32'(strt_cnv), 32'd0);
    chk("rst_chnnl", 32'(chnnl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_line_mask", 32'(line_mask), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("rst_bank", 32'(rd_val), 32'd0);
    end
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 5; v++)
      run_sweep(vecs[v].base, vecs[v].step, vecs[v].thr, vecs[v].lat,
                vecs[v].mask, vecs[v].stray, vecs[v].dup, 1'b0);

    // Reset during channel 3 conversion aborts the sweep and clears everything
    load_tab(100, 100);
    thresh = 12'd450; lat_cfg = 20; stray_en = 0; alt_en = 0;
    conv_cnt = 0; done_cnt = 0; sb.delete(); rd_sel = 3'd0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int n = 0; n < 2000 && conv_cnt < 3 * CONV + 1; n++) @(negedge clk);
    chk("reach_ch3", 32'(conv_cnt >= 3 * CONV + 1), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_strt_cnv", 32'(strt_cnv), 32'd0);
    chk("arst_chnnl", 32'(chnnl), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_line_mask", 32'(line_mask), 32'd0);
    chk("arst_bank0", 32'(rd_val), 32'd0);
    @(negedge clk) rst = 1'b0;
    prev_mask = 8'h00;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("abort_bank", 32'(rd_val), 32'd0);
    end
    $display("reset abort during channel 3 wait, done_cnt=%0d", done_cnt);
    run_sweep(100, 100, 12'd450, 1, 8'hF0, 1'b0, 1'b0, 1'b0);

`ifdef SWEEP_AVG_EN
    run_sweep(4095, 0, 12'd4093, 2, 8'hFF, 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
